// File: rtl/zcache_pkg.sv
// Shared types and helpers for the Z80 CPU read cache controller.
package zcache_pkg;

    typedef enum logic [2:0] {
        SWEEP,
        IDLE,
        LOOKUP,
        FILL_REQ,
        FILL_WAIT,
        WR_REQ
    } zc_state_e;

    localparam int WR_MODE_INVAL  = 0;
    localparam int WR_MODE_UPDATE = 1;

    // Width of one tag-array entry: {valid, tag}.
    function automatic int tag_entry_w(input int aw, input int iw);
        return aw - iw + 1;
    endfunction

endpackage

// File: rtl/zcache_dpram.sv
// Simple dual-port RAM: port A writes, port B reads with one cycle of latency.
module dpram #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] din_a,
    input  logic [AW-1:0] addr_b,
    output logic [DW-1:0] dout_b
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    // Write on port A and register the port B read; a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= din_a;
        end
        dout_b <= mem[addr_b];
    end

endmodule

// File: rtl/zcache_ctrl.sv
// Direct-mapped CPU read cache with registered lookup, write-through writes and a clear sweep.
module zcache_ctrl
    import zcache_pkg::*;
#(
    parameter  int AW      = 21,
    parameter  int IW      = 8,
    parameter  int DW      = 16,
    parameter  int NWIN    = 4,
    parameter  int WR_MODE = 0,
    localparam int WSW     = (NWIN > 1) ? $clog2(NWIN) : 1,
    localparam int NBE     = DW / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [NWIN-1:0]  win_en,
    input  logic [WSW-1:0]   win_sel,
    input  logic             rom_sel,
    input  logic             req_rd,
    input  logic             req_wr,
    input  logic [AW-1:0]    addr,
    input  logic [DW-1:0]    wdata,
    input  logic [NBE-1:0]   wr_be,
    output logic [DW-1:0]    rdata,
    output logic             done,
    output logic             stall,
    output logic             busy,
    output logic             dram_req,
    output logic             dram_rnw,
    output logic [AW-1:0]    dram_addr,
    output logic [DW-1:0]    dram_wdata,
    output logic [NBE-1:0]   dram_be,
    input  logic             dram_ack,
    input  logic             dram_strobe,
    input  logic [DW-1:0]    dram_rddata
);

    localparam int TW  = AW - IW;
    localparam int TEW = tag_entry_w(AW, IW);
    localparam int XW  = IW + 1;

    zc_state_e      state, state_n;
    logic [XW-1:0]  sweep_cnt, idx_q, rd_idx, tag_wa;
    logic [TW-1:0]  tag_q;
    logic           cache_q, flush_pend;
    logic [DW-1:0]  rdata_q, rd_out, data_rd, data_wd, merged;
    logic [TEW-1:0] tag_rd, tag_wd;
    logic           tag_we, data_we, win_ok, cacheable, accept, tag_hit, done_i;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  wdata_q;
    logic [NBE-1:0] be_q;

    // Select the enable bit of the addressed window; out-of-range windows are uncached.
    always_comb begin
        win_ok = 1'b0;
        for (int i = 0; i < NWIN; i++) begin
            if (win_sel == i[WSW-1:0]) begin
                win_ok = win_en[i];
            end
        end
    end

    assign cacheable = win_ok | rom_sel;
    assign accept    = (state == IDLE) && !flush_pend && (req_rd || req_wr);
    assign rd_idx    = (state == IDLE) ? {rom_sel, addr[IW-1:0]} : idx_q;
    assign tag_hit   = tag_rd[TEW-1] && (tag_rd[TW-1:0] == tag_q);

    // Byte-merge the held write data over the old line word for the update policy.
    always_comb begin
        merged = data_rd;
        for (int b = 0; b < NBE; b++) begin
            if (be_q[b]) begin
                merged[b*8 +: 8] = wdata_q[b*8 +: 8];
            end
        end
    end

    dpram #(.DW(TEW), .AW(XW)) u_tag (
        .clk    (clk),
        .we_a   (tag_we),
        .addr_a (tag_wa),
        .din_a  (tag_wd),
        .addr_b (rd_idx),
        .dout_b (tag_rd)
    );

    dpram #(.DW(DW), .AW(XW)) u_data (
        .clk    (clk),
        .we_a   (data_we),
        .addr_a (idx_q),
        .din_a  (data_wd),
        .addr_b (rd_idx),
        .dout_b (data_rd)
    );

    // Next-state decode plus array write controls and completion for the current state.
    always_comb begin
        state_n = state;
        done_i  = 1'b0;
        rd_out  = rdata_q;
        tag_we  = 1'b0;
        tag_wa  = idx_q;
        tag_wd  = '0;
        data_we = 1'b0;
        data_wd = dram_rddata;
        unique case (state)
            SWEEP: begin
                tag_we = 1'b1;
                tag_wa = sweep_cnt;
                if (&sweep_cnt) begin
                    state_n = IDLE;
                end
            end
            IDLE: begin
                if (flush_pend) begin
                    state_n = SWEEP;
                end else if (req_wr) begin
                    state_n = WR_REQ;
                end else if (req_rd) begin
                    state_n = LOOKUP;
                end
            end
            LOOKUP: begin
                if (tag_hit && cache_q) begin
                    done_i  = 1'b1;
                    rd_out  = data_rd;
                    state_n = IDLE;
                end else begin
                    state_n = FILL_REQ;
                end
            end
            FILL_REQ: begin
                if (dram_ack) begin
                    state_n = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                if (dram_strobe) begin
                    done_i  = 1'b1;
                    rd_out  = dram_rddata;
                    tag_we  = cache_q;
                    tag_wd  = {1'b1, tag_q};
                    data_we = cache_q;
                    state_n = IDLE;
                end
            end
            WR_REQ: begin
                if (dram_ack) begin
                    done_i  = 1'b1;
                    state_n = IDLE;
                    if (tag_hit) begin
                        if (WR_MODE == WR_MODE_INVAL) begin
                            tag_we = 1'b1;
                        end else begin
                            data_we = 1'b1;
                            data_wd = merged;
                        end
                    end
                end
            end
            default: state_n = SWEEP;
        endcase
    end

    // State register, sweep counter, flush latch and held read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SWEEP;
            sweep_cnt  <= '0;
            flush_pend <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state      <= state_n;
            sweep_cnt  <= (state == SWEEP) ? sweep_cnt + 1'b1 : '0;
            flush_pend <= flush | (flush_pend & (state != IDLE));
            if (done_i) begin
                rdata_q <= rd_out;
            end
        end
    end

    // Capture the access when it is accepted so DRAM outputs stay stable for the transaction.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= {rom_sel, addr[IW-1:0]};
            tag_q   <= addr[AW-1:IW];
            cache_q <= cacheable;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= req_wr ? wr_be : '1;
        end
    end

    assign done       = rst_n & done_i;
    assign rdata      = done ? rd_out : rdata_q;
    assign busy       = (state == SWEEP);
    assign stall      = busy | ((req_rd | req_wr) & ~done);
    assign dram_req   = rst_n & ((state == FILL_REQ) || (state == WR_REQ));
    assign dram_rnw   = (state != WR_REQ);
    assign dram_addr  = addr_q;
    assign dram_wdata = wdata_q;
    assign dram_be    = be_q;

endmodule
